writeback_stage: RTL and testbench

//  Final pipeline stage; writer side of the register-file port that decode reads (wen/wa/wd).

---
 rtl/writeback_stage_pkg.sv | 26 ++
 rtl/writeback_stage_load_extract.sv | 32 +++
 rtl/writeback_stage.sv | 118 +++++++++++
 tb/tb_writeback_stage.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_stage_pkg.sv
// Shared types for the writeback stage: register-file words, addresses, load sizes, buffer entries.
// Latency: n/a (types only).
// Backpressure: n/a.
package writeback_stage_pkg;

  typedef logic [63:0] word_t;
  typedef logic [4:0]  creg_addr_t;

  // Load access size, encoded as log2 of the byte count
  typedef enum logic [1:0] {
    MSIZE1 = 2'b00,
    MSIZE2 = 2'b01,
    MSIZE4 = 2'b10,
    MSIZE8 = 2'b11
  } mem_size_t;

  // One in-order buffer slot; data already holds the final register value
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] raw_instr;
    creg_addr_t  dst;
    logic        regwrite;
    word_t       data;
  } wb_entry_t;

endpackage

// File: rtl/writeback_stage_load_extract.sv
// Load data extraction: picks the addressed byte/half/word/dword and sign- or zero-extends it.
// Latency: purely combinational.
// Backpressure: none.
module writeback_stage_load_extract
  import writeback_stage_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [63:0] result
);

  mem_size_t   sz;
  logic [63:0] shifted;

  assign sz      = mem_size_t'(size);
  assign shifted = rdata >> {addr_lo, 3'b000};

  // Select the access width from the shifted data; a dword ignores the byte offset
  always_comb begin
    result = '0;
    case (sz)
      MSIZE1: result = is_unsigned ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
      MSIZE2: result = is_unsigned ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      MSIZE4: result = is_unsigned ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      MSIZE8: result = rdata;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: buffers memory-stage results in order and retires one per cycle to the regfile/commit port.
// Latency: 1 cycle minimum from accept to head; no combinational input-to-output path.
// Backpressure: in_ready = !full from registered occupancy; commit_ready low holds the head entry.
module writeback_stage #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_pc,
  input  logic [31:0]      in_raw_instr,
  input  logic [4:0]       in_dst,
  input  logic             in_regwrite,
  input  logic             in_memtoreg,
  input  logic [1:0]       in_mem_size,
  input  logic             in_mem_unsigned,
  input  logic [2:0]       in_addr_lo,
  input  logic [63:0]      in_alu_result,
  input  logic [63:0]      in_mem_rdata,
  input  logic             commit_ready,
  output logic             wen,
  output logic [4:0]       wa,
  output logic [63:0]      wd,
  output logic             fwd_valid,
  output logic [4:0]       fwd_dst,
  output logic [63:0]      fwd_data,
  output logic             commit_valid,
  output logic [63:0]      commit_pc,
  output logic [31:0]      commit_instr,
  output logic [CNT_W-1:0] retired_count
);

  import writeback_stage_pkg::*;

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  wb_entry_t        entries [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [LVL_W-1:0] level;

  wb_entry_t head_entry;
  word_t     load_val;
  word_t     enq_data;
  logic      head_valid;
  logic      head_writes;
  logic      push;
  logic      fire;

  writeback_stage_load_extract u_load_extract (
    .rdata       (in_mem_rdata),
    .addr_lo     (in_addr_lo),
    .size        (in_mem_size),
    .is_unsigned (in_mem_unsigned),
    .result      (load_val)
  );

  assign enq_data    = in_memtoreg ? load_val : in_alu_result;
  assign in_ready    = (level != FULL_LVL);
  assign head_valid  = (level != '0);
  assign head_entry  = entries[head];
  assign head_writes = head_valid && head_entry.regwrite && (head_entry.dst != '0);
  // Reset suppresses both sides so nothing is accepted or written during the reset cycle
  assign push        = in_valid && in_ready && !reset;
  assign fire        = head_valid && commit_ready && !reset;

  // Entry storage: written at the tail on accept, no reset needed since occupancy gates use
  always_ff @(posedge clk) begin
    if (push) begin
      entries[tail] <= '{pc: in_pc, raw_instr: in_raw_instr, dst: in_dst,
                         regwrite: in_regwrite, data: enq_data};
    end
  end

  // Pointers, occupancy and retirement counter; simultaneous push and pop leave occupancy unchanged
  always_ff @(posedge clk) begin
    if (reset) begin
      head          <= '0;
      tail          <= '0;
      level         <= '0;
      retired_count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (fire) begin
        head          <= head + PTR_W'(1);
        retired_count <= retired_count + CNT_W'(1);
      end
      if (push && !fire)      level <= level + LVL_W'(1);
      else if (!push && fire) level <= level - LVL_W'(1);
    end
  end

  // Head presentation: write/commit strobes only on retirement, fields zero when empty
  always_comb begin
    wen          = fire && head_writes;
    commit_valid = fire;
    wa           = '0;
    wd           = '0;
    commit_pc    = '0;
    commit_instr = '0;
    fwd_valid    = head_writes;
    fwd_dst      = '0;
    fwd_data     = '0;
    if (head_valid) begin
      wa           = head_entry.dst;
      wd           = head_entry.data;
      commit_pc    = head_entry.pc;
      commit_instr = head_entry.raw_instr;
      fwd_dst      = head_entry.dst;
      fwd_data     = head_entry.data;
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: queue-based reference model plus directed literal checks and random traffic.
// Latency: n/a.
// Backpressure: n/a.
module tb_writeback_stage;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [31:0] in_raw_instr;
  logic [4:0]  in_dst;
  logic        in_regwrite;
  logic        in_memtoreg;
  logic [1:0]  in_mem_size;
  logic        in_mem_unsigned;
  logic [2:0]  in_addr_lo;
  logic [63:0] in_alu_result;
  logic [63:0] in_mem_rdata;
  logic        commit_ready;
  logic        wen;
  logic [4:0]  wa;
  logic [63:0] wd;
  logic        fwd_valid;
  logic [4:0]  fwd_dst;
  logic [63:0] fwd_data;
  logic        commit_valid;
  logic [63:0] commit_pc;
  logic [31:0] commit_instr;
  logic [63:0] retired_count;

  writeback_stage #(.DEPTH(DEPTH), .CNT_W(64)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_raw_instr(in_raw_instr), .in_dst(in_dst),
    .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg), .in_mem_size(in_mem_size),
    .in_mem_unsigned(in_mem_unsigned), .in_addr_lo(in_addr_lo),
    .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata),
    .commit_ready(commit_ready), .wen(wen), .wa(wa), .wd(wd),
    .fwd_valid(fwd_valid), .fwd_dst(fwd_dst), .fwd_data(fwd_data),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_instr(commit_instr),
    .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [4:0]  dst;
    logic        rw;
    logic [63:0] data;
  } ment_t;

  ment_t       q[$];
  logic [63:0] rc;
  int          nvec = 0;
  int          nfail = 0;

  // Load value from first principles: take the bytes at the offset, then extend
  function automatic logic [63:0] ext(logic [63:0] rd, int addr, int size, bit uns);
    int bits;
    logic [63:0] v, mask;
    if (size == 3) return rd;
    bits = 8 << size;
    v    = rd >> (addr * 8);
    mask = (64'd1 << bits) - 64'd1;
    v    = v & mask;
    if (!uns && v[bits-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare every output against the model in the middle of the cycle
  task automatic check_cycle();
    bit hv, f, hw;
    ment_t h;
    @(negedge clk);
    hv = (q.size() > 0);
    h  = '{pc: 64'd0, instr: 32'd0, dst: 5'd0, rw: 1'b0, data: 64'd0};
    if (hv) h = q[0];
    f  = hv && commit_ready && !reset;
    hw = hv && h.rw && (h.dst != 5'd0);
    chk("in_ready",      in_ready,      q.size() < DEPTH);
    chk("commit_valid",  commit_valid,  f);
    chk("wen",           wen,           f && hw);
    chk("wa",            wa,            h.dst);
    chk("wd",            wd,            h.data);
    chk("commit_pc",     commit_pc,     h.pc);
    chk("commit_instr",  commit_instr,  h.instr);
    chk("fwd_valid",     fwd_valid,     hw);
    chk("fwd_dst",       fwd_dst,       h.dst);
    chk("fwd_data",      fwd_data,      h.data);
    chk("retired_count", retired_count, rc);
  endtask

  // Apply the clock edge to the model using the inputs held this cycle
  task automatic advance();
    bit p, f;
    ment_t e;
    p = in_valid && (q.size() < DEPTH) && !reset;
    f = (q.size() > 0) && commit_ready && !reset;
    e.pc    = in_pc;
    e.instr = in_raw_instr;
    e.dst   = in_dst;
    e.rw    = in_regwrite;
    e.data  = in_memtoreg ? ext(in_mem_rdata, int'(in_addr_lo), int'(in_mem_size), in_mem_unsigned)
                          : in_alu_result;
    @(posedge clk);
    if (reset) begin
      q.delete();
      rc = 64'd0;
    end else begin
      if (f) begin
        void'(q.pop_front());
        rc = rc + 64'd1;
      end
      if (p) q.push_back(e);
    end
    #1;
  endtask

  task automatic tick();
    check_cycle();
    advance();
  endtask

  task automatic set_instr(logic [63:0] pc, logic [4:0] dst, logic rw, logic m2r, logic [1:0] sz,
                           logic uns, logic [2:0] addr, logic [63:0] alu, logic [63:0] rdata);
    in_valid        = 1'b1;
    in_pc           = pc;
    in_raw_instr    = pc[31:0] ^ 32'h0000_0013;
    in_dst          = dst;
    in_regwrite     = rw;
    in_memtoreg     = m2r;
    in_mem_size     = sz;
    in_mem_unsigned = uns;
    in_addr_lo      = addr;
    in_alu_result   = alu;
    in_mem_rdata    = rdata;
  endtask

  task automatic set_random();
    set_instr({$urandom, $urandom}, 5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom),
              2'($urandom), 1'($urandom), 3'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rc = 64'd0;
    reset = 1'b1;
    commit_ready = 1'b1;
    set_instr(64'h10, 5'd3, 1'b1, 1'b0, 2'd0, 1'b0, 3'd0, 64'h55, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    q.delete();

    // 1: reset held with in_valid=1 must not enqueue
    check_cycle();
    chk("t1_rst_wen", wen, 64'd0);
    advance();
    reset = 1'b0;
    in_valid = 1'b0;
    check_cycle();
    chk("t1_in_ready", in_ready, 64'd1);
    chk("t1_count", retired_count, 64'd0);
    chk("t1_wen", wen, 64'd0);
    chk("t1_cv", commit_valid, 64'd0);
    advance();

    // 2: plain ALU result
    set_instr(64'h1000, 5'd5, 1'b1, 1'b0, 2'd0, 1'b0, 3'd0, 64'h1234, 64'd0);
    tick();
    in_valid = 1'b0;
    check_cycle();
    chk("t2_wen", wen, 64'd1);
    chk("t2_wa", wa, 64'd5);
    chk("t2_wd", wd, 64'h1234);
    chk("t2_cv", commit_valid, 64'd1);
    advance();
    check_cycle();
    chk("t2_count", retired_count, 64'd1);
    advance();

    // 3: load extraction variants
    set_instr(64'h1004, 5'd6, 1'b1, 1'b1, 2'd0, 1'b0, 3'd2, 64'hdead, 64'h0000_0000_0080_0000);
    tick();
    in_valid = 1'b0;
    check_cycle();
    chk("t3_lb", wd, 64'hFFFF_FFFF_FFFF_FF80);
    advance();
    set_instr(64'h1008, 5'd6, 1'b1, 1'b1, 2'd0, 1'b1, 3'd2, 64'hdead, 64'h0000_0000_0080_0000);
    tick();
    in_valid = 1'b0;
    check_cycle();
    chk("t3_lbu", wd, 64'h80);
    advance();
    set_instr(64'h100c, 5'd7, 1'b1, 1'b1, 2'd2, 1'b0, 3'd4, 64'd0, 64'h8000_0001_0000_0000);
    tick();
    in_valid = 1'b0;
    check_cycle();
    chk("t3_lw", wd, 64'hFFFF_FFFF_8000_0001);
    advance();
    set_instr(64'h1010, 5'd8, 1'b1, 1'b1, 2'd3, 1'b0, 3'd5, 64'd0, 64'hDEAD_BEEF_0123_4567);
    tick();
    in_valid = 1'b0;
    check_cycle();
    chk("t3_ld", wd, 64'hDEAD_BEEF_0123_4567);
    advance();

    // 4: x0 destination retires but never writes or forwards
    set_instr(64'h1014, 5'd0, 1'b1, 1'b0, 2'd0, 1'b0, 3'd0, 64'h99, 64'd0);
    tick();
    in_valid = 1'b0;
    check_cycle();
    chk("t4_cv", commit_valid, 64'd1);
    chk("t4_wen", wen, 64'd0);
    chk("t4_fwd", fwd_valid, 64'd0);
    advance();

    // 5: stall commit, fill the buffer, then drain in order
    commit_ready = 1'b0;
    set_instr(64'h2000, 5'd1, 1'b1, 1'b0, 2'd0, 1'b0, 3'd0, 64'hA, 64'd0);
    tick();
    set_instr(64'h2004, 5'd2, 1'b1, 1'b0, 2'd0, 1'b0, 3'd0, 64'hB, 64'd0);
    check_cycle();
    chk("t5_fwd_hold", fwd_data, 64'hA);
    advance();
    set_instr(64'h2008, 5'd3, 1'b1, 1'b0, 2'd0, 1'b0, 3'd0, 64'hC, 64'd0);
    check_cycle();
    chk("t5_full", in_ready, 64'd0);
    advance();
    commit_ready = 1'b1;
    check_cycle();
    chk("t5_pc0", commit_pc, 64'h2000);
    chk("t5_full_fire", in_ready, 64'd0);
    advance();
    check_cycle();
    chk("t5_pc1", commit_pc, 64'h2004);
    chk("t5_rdy", in_ready, 64'd1);
    advance();
    in_valid = 1'b0;
    check_cycle();
    chk("t5_pc2", commit_pc, 64'h2008);
    chk("t5_wd2", wd, 64'hC);
    advance();
    check_cycle();
    chk("t5_empty", commit_valid, 64'd0);
    advance();

    // 6: sustained stream, then reset mid-stream
    for (int i = 0; i < 20; i++) begin
      set_random();
      in_pc = 64'h3000 + 64'(i * 4);
      check_cycle();
      if (i > 0) chk("t6_rate", commit_valid, 64'd1);
      advance();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    check_cycle();
    chk("t6_count", retired_count, 64'd0);
    chk("t6_cv", commit_valid, 64'd0);
    chk("t6_rdy", in_ready, 64'd1);
    advance();

    // Random traffic with occasional resets and commit stalls
    for (int i = 0; i < 3000; i++) begin
      set_random();
      in_valid     = ($urandom_range(0, 3) != 0);
      commit_ready = ($urandom_range(0, 3) != 0);
      reset        = ($urandom_range(0, 99) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
